// File: rtl/neat_xover_pkg.sv
// Shared definitions for the NEAT crossover aligner: selection codes, FSM
// state encoding and the LFSR seed.
package neat_xover_pkg;

  localparam logic [1:0] SEL_G1  = 2'b10;
  localparam logic [1:0] SEL_G2  = 2'b11;
  localparam logic [1:0] SEL_END = 2'b01;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_END   = 2'd3
  } xover_state_t;

endpackage

// File: rtl/neat_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting right;
// bit_out is the current bit 0, and the register advances only when en is high.
module neat_lfsr16
  import neat_xover_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_out
);

  logic [15:0] value;

  assign bit_out = value[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED;
    end else if (en) begin
      value <= {value[0] ^ value[2] ^ value[3] ^ value[5], value[15:1]};
    end
  end

endmodule

// File: rtl/crossover_aligner.sv
// Merges two innovation-sorted gene streams of NEAT parents into one stream of
// selection words (take g1 / take g2 / end), counting match, disjoint and excess genes.
module crossover_aligner
  import neat_xover_pkg::*;
#(
  parameter int INNOV_W    = 8,
  parameter int FIT_W      = 8,
  parameter int SIZE_W     = 8,
  parameter int MATCH_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SIZE_W-1:0]  g1_size,
  input  logic [SIZE_W-1:0]  g2_size,
  input  logic [FIT_W-1:0]   g1_fitness,
  input  logic [FIT_W-1:0]   g2_fitness,
  input  logic               g1_valid,
  input  logic               g2_valid,
  input  logic [INNOV_W-1:0] g1_innov,
  input  logic [INNOV_W-1:0] g2_innov,
  output logic               g1_ready,
  output logic               g2_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_sel,
  output logic [INNOV_W-1:0] out_innov,
  output logic               busy,
  output logic [SIZE_W-1:0]  n_match,
  output logic [SIZE_W-1:0]  n_disjoint,
  output logic [SIZE_W-1:0]  n_excess,
  output xover_state_t       dbg_state
);

  // Handshakes: a transfer happens on every rising clk where valid and ready
  // are both high. Valid never waits on ready; in MERGE the gX_ready lines
  // depend on both stream valids so neither stream moves before the compare.

  function automatic logic [SIZE_W-1:0] sat_inc(input logic [SIZE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  xover_state_t       state;
  logic [SIZE_W-1:0]  s1, s2, c1, c2;
  logic [FIT_W-1:0]   f1, f2;
  logic               out_free, g1_done, g2_done, t1, t2, f1_ok, f2_ok;
  logic               lfsr_bit, end_go, load;
  logic [1:0]         match_sel, load_sel;
  logic [INNOV_W-1:0] load_innov;

  assign dbg_state = state;
  assign out_free  = !out_valid || out_ready;
  assign g1_done   = (c1 >= s1);
  assign g2_done   = (c2 >= s2);
  assign t1        = g1_valid && g1_ready;
  assign t2        = g2_valid && g2_ready;
  assign f1_ok     = (f1 >= f2);
  assign f2_ok     = (f2 >= f1);
  assign end_go    = (state == ST_DRAIN) && g1_done && g2_done && out_free;
  assign match_sel = (MATCH_MODE != 0) ? (lfsr_bit ? SEL_G2 : SEL_G1)
                                       : (f1_ok ? SEL_G1 : SEL_G2);

  neat_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en      (t1 && t2),
    .bit_out (lfsr_bit)
  );

  always_comb begin
    g1_ready = 1'b0;
    g2_ready = 1'b0;
    case (state)
      ST_MERGE: if (out_free && g1_valid && g2_valid) begin
        g1_ready = (g1_innov <= g2_innov);
        g2_ready = (g2_innov <= g1_innov);
      end
      ST_DRAIN: if (out_free) begin
        g1_ready = !g1_done;
        g2_ready = g1_done && !g2_done;
      end
      default: ;
    endcase
  end

  // Word to place in the single output register this cycle, if any.
  always_comb begin
    load       = 1'b0;
    load_sel   = SEL_G1;
    load_innov = '0;
    if (t1 && t2) begin
      load       = 1'b1;
      load_sel   = match_sel;
      load_innov = g1_innov;
    end else if (t1) begin
      load       = f1_ok;
      load_innov = g1_innov;
    end else if (t2) begin
      load       = f2_ok;
      load_sel   = SEL_G2;
      load_innov = g2_innov;
    end else if (end_go) begin
      load       = 1'b1;
      load_sel   = SEL_END;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_sel    <= 2'b00;
      out_innov  <= '0;
      busy       <= 1'b0;
      s1         <= '0;
      s2         <= '0;
      c1         <= '0;
      c2         <= '0;
      f1         <= '0;
      f2         <= '0;
      n_match    <= '0;
      n_disjoint <= '0;
      n_excess   <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (load) begin
        out_valid <= 1'b1;
        out_sel   <= load_sel;
        out_innov <= load_innov;
      end
      if (t1) c1 <= sat_inc(c1);
      if (t2) c2 <= sat_inc(c2);
      case (state)
        ST_IDLE: if (start) begin
          s1         <= g1_size;
          s2         <= g2_size;
          f1         <= g1_fitness;
          f2         <= g2_fitness;
          c1         <= '0;
          c2         <= '0;
          n_match    <= '0;
          n_disjoint <= '0;
          n_excess   <= '0;
          busy       <= 1'b1;
          if (g1_size == '0 && g2_size == '0) begin
            state     <= ST_END;
            out_valid <= 1'b1;
            out_sel   <= SEL_END;
            out_innov <= '0;
          end else if (g1_size == '0 || g2_size == '0) begin
            state <= ST_DRAIN;
          end else begin
            state <= ST_MERGE;
          end
        end
        ST_MERGE: begin
          if (t1 && t2) n_match <= sat_inc(n_match);
          else if (t1 || t2) n_disjoint <= sat_inc(n_disjoint);
          if ((t1 && sat_inc(c1) == s1) || (t2 && sat_inc(c2) == s2)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (t1 || t2) n_excess <= sat_inc(n_excess);
          if (end_go) state <= ST_END;
        end
        ST_END: if (out_valid && out_ready) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crossover_aligner.sv
// Bench for crossover_aligner: directed vector table, held-output, reset and
// throttled random crossovers against a list-merge reference model.
module tb_crossover_aligner;
  import neat_xover_pkg::*;

  localparam int W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] g1_size = '0, g2_size = '0, g1_fitness = '0, g2_fitness = '0;
  logic       g1_valid = 1'b0, g2_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] g1_innov = '0, g2_innov = '0;

  logic         g1_ready_a, g2_ready_a, out_valid_a, busy_a;
  logic [1:0]   out_sel_a;
  logic [7:0]   out_innov_a, n_match_a, n_disjoint_a, n_excess_a;
  xover_state_t dbg_state_a;
  logic         g1_ready_b, g2_ready_b, out_valid_b, busy_b;
  logic [1:0]   out_sel_b;
  logic [7:0]   out_innov_b, n_match_b, n_disjoint_b, n_excess_b;
  xover_state_t dbg_state_b;

  crossover_aligner #(.MATCH_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .g1_size(g1_size), .g2_size(g2_size),
    .g1_fitness(g1_fitness), .g2_fitness(g2_fitness),
    .g1_valid(g1_valid), .g2_valid(g2_valid),
    .g1_innov(g1_innov), .g2_innov(g2_innov),
    .g1_ready(g1_ready_a), .g2_ready(g2_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sel(out_sel_a), .out_innov(out_innov_a), .busy(busy_a),
    .n_match(n_match_a), .n_disjoint(n_disjoint_a), .n_excess(n_excess_a),
    .dbg_state(dbg_state_a)
  );

  crossover_aligner #(.MATCH_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .g1_size(g1_size), .g2_size(g2_size),
    .g1_fitness(g1_fitness), .g2_fitness(g2_fitness),
    .g1_valid(g1_valid), .g2_valid(g2_valid),
    .g1_innov(g1_innov), .g2_innov(g2_innov),
    .g1_ready(g1_ready_b), .g2_ready(g2_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sel(out_sel_b), .out_innov(out_innov_b), .busy(busy_b),
    .n_match(n_match_b), .n_disjoint(n_disjoint_b), .n_excess(n_excess_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard state ----------------
  int           errors = 0;
  int           checks = 0;
  string        ctx = "reset";
  logic [7:0]   g1_q[$], g2_q[$];
  logic [W-1:0] exp_q[$], got_q[$];
  logic [15:0]  tb_lfsr = LFSR_SEED;
  int           em, ed, ee;

  typedef struct {
    logic [7:0]   g1 [4];
    int           n1;
    logic [7:0]   g2 [4];
    int           n2;
    logic [7:0]   f1, f2;
    logic [W-1:0] ex [6];
    int           n_ex;
    int           xm, xd, xe;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h, want %0h", ctx, name, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Reference: plain merge of two sorted lists, fitter-parent rule for disjoint/excess.
  function automatic void build_exp(input bit mode, input logic [7:0] f1, input logic [7:0] f2);
    int i = 0;
    int j = 0;
    exp_q.delete();
    em = 0; ed = 0; ee = 0;
    while (i < g1_q.size() && j < g2_q.size()) begin
      if (g1_q[i] == g2_q[j]) begin
        em++;
        if (mode ? tb_lfsr[0] : (f1 < f2)) exp_q.push_back({SEL_G2, g1_q[i]});
        else exp_q.push_back({SEL_G1, g1_q[i]});
        tb_lfsr = lfsr_step(tb_lfsr);
        i++; j++;
      end else if (g1_q[i] < g2_q[j]) begin
        ed++;
        if (f1 >= f2) exp_q.push_back({SEL_G1, g1_q[i]});
        i++;
      end else begin
        ed++;
        if (f2 >= f1) exp_q.push_back({SEL_G2, g2_q[j]});
        j++;
      end
    end
    for (; i < g1_q.size(); i++) begin
      ee++;
      if (f1 >= f2) exp_q.push_back({SEL_G1, g1_q[i]});
    end
    for (; j < g2_q.size(); j++) begin
      ee++;
      if (f2 >= f1) exp_q.push_back({SEL_G2, g2_q[j]});
    end
    exp_q.push_back({SEL_END, 8'h00});
  endfunction

  // ---------------- driver ----------------
  // Starts a crossover from g1_q/g2_q and collects accepted words into got_q.
  task automatic run_one(input bit use_b, input bit throttle);
    int i1, i2, cyc;
    bit done, held, x1, x2, ov;
    logic [W-1:0] word, held_word;
    i1 = 0; i2 = 0; cyc = 0; done = 0; held = 0; x1 = 0; x2 = 0;
    held_word = '0;
    got_q.delete();
    g1_size = 8'(g1_q.size());
    g2_size = 8'(g2_q.size());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", use_b ? busy_b : busy_a, 1);
    while (!done && cyc < 2000) begin
      if (x1) g1_valid = 1'b0;
      if (x2) g2_valid = 1'b0;
      if (!g1_valid) g1_valid = (i1 < g1_q.size()) && (!throttle || $urandom_range(0, 3) != 0);
      if (!g2_valid) g2_valid = (i2 < g2_q.size()) && (!throttle || $urandom_range(0, 3) != 0);
      g1_innov = g1_valid ? g1_q[i1] : 8'h00;
      g2_innov = g2_valid ? g2_q[i2] : 8'h00;
      out_ready = !throttle || ($urandom_range(0, 2) != 0);
      #1;
      x1 = g1_valid && (use_b ? g1_ready_b : g1_ready_a);
      x2 = g2_valid && (use_b ? g2_ready_b : g2_ready_a);
      ov = use_b ? out_valid_b : out_valid_a;
      word = use_b ? {out_sel_b, out_innov_b} : {out_sel_a, out_innov_a};
      if (held) check("hold_stable", {ov, word}, {1'b1, held_word});
      held = ov && !out_ready;
      held_word = word;
      @(posedge clk);
      if (x1) i1++;
      if (x2) i2++;
      if (ov && out_ready) begin
        got_q.push_back(word);
        if (word[W-1:W-2] == SEL_END) done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    g1_valid = 1'b0;
    g2_valid = 1'b0;
    out_ready = 1'b1;
    check("finished", done, 1);
    check("g1_consumed", i1, g1_q.size());
    check("g2_consumed", i2, g2_q.size());
    check("busy_after_end", use_b ? busy_b : busy_a, 0);
  endtask

  task automatic compare_run(input bit use_b, input int xm, input int xd, input int xe);
    check("n_words", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("word%0d", i), got_q[i], exp_q[i]);
    check("n_match", use_b ? n_match_b : n_match_a, xm);
    check("n_disjoint", use_b ? n_disjoint_b : n_disjoint_a, xd);
    check("n_excess", use_b ? n_excess_b : n_excess_a, xe);
  endtask

  task automatic load_vec(input int k);
    g1_q.delete();
    g2_q.delete();
    exp_q.delete();
    for (int i = 0; i < vecs[k].n1; i++) g1_q.push_back(vecs[k].g1[i]);
    for (int i = 0; i < vecs[k].n2; i++) g2_q.push_back(vecs[k].g2[i]);
    for (int i = 0; i < vecs[k].n_ex; i++) exp_q.push_back(vecs[k].ex[i]);
    g1_fitness = vecs[k].f1;
    g2_fitness = vecs[k].f2;
  endtask

  task automatic run_vec(input int k, input bit throttle);
    load_vec(k);
    run_one(0, throttle);
    compare_run(0, vecs[k].xm, vecs[k].xd, vecs[k].xe);
    for (int m = 0; m < vecs[k].xm; m++) tb_lfsr = lfsr_step(tb_lfsr);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] f1, f2;
    int n1max, n2max;

    vecs[0].g1 = '{8'd1, 8'd2, 8'd4, 8'd0}; vecs[0].n1 = 3;
    vecs[0].g2 = '{8'd1, 8'd3, 8'd4, 8'd0}; vecs[0].n2 = 3;
    vecs[0].f1 = 8'd9; vecs[0].f2 = 8'd5;
    vecs[0].ex = '{10'h201, 10'h202, 10'h204, 10'h100, 10'h0, 10'h0}; vecs[0].n_ex = 4;
    vecs[0].xm = 2; vecs[0].xd = 2; vecs[0].xe = 0;

    vecs[1].g1 = '{8'd1, 8'd2, 8'd0, 8'd0}; vecs[1].n1 = 2;
    vecs[1].g2 = '{8'd1, 8'd2, 8'd5, 8'd6}; vecs[1].n2 = 4;
    vecs[1].f1 = 8'd3; vecs[1].f2 = 8'd7;
    vecs[1].ex = '{10'h301, 10'h302, 10'h305, 10'h306, 10'h100, 10'h0}; vecs[1].n_ex = 5;
    vecs[1].xm = 2; vecs[1].xd = 0; vecs[1].xe = 2;

    vecs[2].g1 = '{8'd2, 8'd0, 8'd0, 8'd0}; vecs[2].n1 = 1;
    vecs[2].g2 = '{8'd1, 8'd3, 8'd0, 8'd0}; vecs[2].n2 = 2;
    vecs[2].f1 = 8'd4; vecs[2].f2 = 8'd4;
    vecs[2].ex = '{10'h301, 10'h202, 10'h303, 10'h100, 10'h0, 10'h0}; vecs[2].n_ex = 4;
    vecs[2].xm = 0; vecs[2].xd = 2; vecs[2].xe = 1;

    vecs[3].g1 = '{8'd5, 8'd6, 8'd7, 8'd0}; vecs[3].n1 = 3;
    vecs[3].g2 = '{8'd0, 8'd0, 8'd0, 8'd0}; vecs[3].n2 = 0;
    vecs[3].f1 = 8'd2; vecs[3].f2 = 8'd8;
    vecs[3].ex = '{10'h100, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0}; vecs[3].n_ex = 1;
    vecs[3].xm = 0; vecs[3].xd = 0; vecs[3].xe = 3;

    vecs[4].g1 = '{8'd3, 8'd0, 8'd0, 8'd0}; vecs[4].n1 = 1;
    vecs[4].g2 = '{8'd3, 8'd0, 8'd0, 8'd0}; vecs[4].n2 = 1;
    vecs[4].f1 = 8'd1; vecs[4].f2 = 8'd1;
    vecs[4].ex = '{10'h203, 10'h100, 10'h0, 10'h0, 10'h0, 10'h0}; vecs[4].n_ex = 2;
    vecs[4].xm = 1; vecs[4].xd = 0; vecs[4].xe = 0;

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(negedge clk);
    check("out_valid", out_valid_a, 0);
    check("busy", busy_a, 0);
    check("g1_ready", g1_ready_a, 0);
    check("g2_ready", g2_ready_a, 0);
    check("out_sel", out_sel_a, 0);
    check("out_innov", out_innov_a, 0);
    check("n_match", n_match_a, 0);
    check("n_excess", n_excess_a, 0);
    check("state", dbg_state_a, ST_IDLE);
    check("out_valid_b", out_valid_b, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table, free-running then throttled.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 5; k++) begin
        ctx = $sformatf("vec%0d_p%0d", k, pass);
        run_vec(k, pass[0]);
      end
    end

    // Empty genomes: only the end word, held while out_ready is low.
    ctx = "empty_hold";
    g1_q.delete();
    g2_q.delete();
    g1_size = 8'd0;
    g2_size = 8'd0;
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("valid%0d", k), out_valid_a, 1);
      check($sformatf("word%0d", k), {out_sel_a, out_innov_a}, 10'h100);
      check($sformatf("busy%0d", k), busy_a, 1);
      check($sformatf("g1_ready%0d", k), g1_ready_a, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_after", out_valid_a, 0);
    check("busy_after", busy_a, 0);
    check("state_after", dbg_state_a, ST_IDLE);

    // Asynchronous reset in the middle of MERGE with a word held.
    ctx = "mid_reset";
    g1_size = 8'd3;
    g2_size = 8'd3;
    g1_fitness = 8'd9;
    g2_fitness = 8'd5;
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g1_valid = 1'b1;
    g2_valid = 1'b1;
    g1_innov = 8'd1;
    g2_innov = 8'd1;
    @(negedge clk);
    g1_valid = 1'b0;
    g2_valid = 1'b0;
    check("held_valid", out_valid_a, 1);
    check("held_state", dbg_state_a, ST_MERGE);
    #2 rst = 1'b0;
    #1;
    check("valid_in_rst", out_valid_a, 0);
    check("busy_in_rst", busy_a, 0);
    check("state_in_rst", dbg_state_a, ST_IDLE);
    check("sel_in_rst", out_sel_a, 0);
    check("busy_b_in_rst", busy_b, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    tb_lfsr = LFSR_SEED;
    @(negedge clk);
    ctx = "after_reset";
    run_vec(0, 1'b0);

    // Random throttled crossovers on the LFSR-selecting instance.
    for (int g = 0; g < 200; g++) begin
      ctx = $sformatf("rand%0d", g);
      g1_q.delete();
      g2_q.delete();
      n1max = $urandom_range(0, 6);
      n2max = $urandom_range(0, 6);
      for (int v = 1; v <= 40; v++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 2 && g1_q.size() < n1max && g2_q.size() < n2max) begin
          g1_q.push_back(8'(v));
          g2_q.push_back(8'(v));
        end else if (r < 4 && g1_q.size() < n1max) begin
          g1_q.push_back(8'(v));
        end else if (r < 6 && g2_q.size() < n2max) begin
          g2_q.push_back(8'(v));
        end
      end
      f1 = 8'($urandom_range(0, 3));
      f2 = 8'($urandom_range(0, 3));
      g1_fitness = f1;
      g2_fitness = f2;
      build_exp(1'b1, f1, f2);
      run_one(1'b1, 1'b1);
      compare_run(1'b1, em, ed, ee);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crossover_aligner.md
CROSSOVER_ALIGNER -- requirements
Module: crossover_aligner

Interface
REQ-001 SHALL have parameter INNOV_W, default 8, innovation-number width.
REQ-002 SHALL have parameter FIT_W, default 8, fitness width.
REQ-003 SHALL have parameter SIZE_W, default 8, genome-size width in genes.
REQ-004 SHALL have parameter MATCH_MODE, default 0; 0 = matching gene from fitter parent, 1 = matching gene by LFSR bit.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, a one-cycle pulse that begins a crossover; honoured in IDLE only.
REQ-008 SHALL have ports g1_size and g2_size, input, SIZE_W, gene counts, sampled at start.
REQ-009 SHALL have ports g1_fitness and g2_fitness, input, FIT_W, parent fitness, sampled at start.
REQ-010 SHALL have ports g1_valid and g2_valid, input, 1, stream valid flags.
REQ-011 SHALL have ports g1_innov and g2_innov, input, INNOV_W, gene innovation numbers, ascending per stream.
REQ-012 SHALL have ports g1_ready and g2_ready, output, 1, stream accepts.
REQ-013 SHALL have port out_valid, output, 1, selection word valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accept.
REQ-015 SHALL have port out_sel, output, 2, selection code: 10 = take g1 gene, 11 = take g2 gene, 01 = end of offspring.
REQ-016 SHALL have port out_innov, output, INNOV_W, innovation number of the selected gene.
REQ-017 SHALL have port busy, output, 1, high from the cycle after an accepted start until the 01 word is accepted.
REQ-018 SHALL have ports n_match, n_disjoint and n_excess, output, SIZE_W each, per-crossover gene class counts.

Function
REQ-019 SHALL implement the FSM IDLE -> MERGE -> DRAIN -> END -> IDLE.
REQ-020 On start in IDLE, SHALL latch sizes and fitness, clear the consumed-counters and class counters, and enter MERGE.
REQ-021 A stream transfer SHALL occur when gX_valid and gX_ready are high on the same clk edge; an out transfer SHALL occur when out_valid and out_ready are high on the same edge.
REQ-022 The output SHALL be a single register: gX_ready high only in MERGE/DRAIN when the out register is empty or transferring this cycle.
REQ-023 In MERGE, both streams SHALL be held until both are valid, then compared.
REQ-024 On equal innov, SHALL consume both streams and increment n_match.
REQ-025 For a matching gene with MATCH_MODE=0, SHALL emit 10 if g1_fitness >= g2_fitness, else 11.
REQ-026 For a matching gene with MATCH_MODE=1, SHALL emit 10 if the LFSR bit is 0, else 11.
REQ-027 On unequal innov, SHALL consume only the lower stream and increment n_disjoint.
REQ-028 An unequal (disjoint) gene SHALL be emitted only if its parent is fitter, or if fitness is equal.
REQ-029 MERGE SHALL go to DRAIN when either consumed-count reaches its size.
REQ-030 In DRAIN, each remaining gene of the other stream SHALL be consumed and n_excess incremented.
REQ-031 An excess gene SHALL be emitted under the same fitness rule as a disjoint gene.
REQ-032 DRAIN SHALL go to END when both counts reach size.
REQ-033 In END, SHALL present out_sel=01 with out_innov=0 and hold it until accepted, then return to IDLE.
REQ-034 Output latency SHALL be exactly one cycle from stream transfer to out_valid.
REQ-035 out_sel/out_innov SHALL be stable while out_valid is high and out_ready is low.
REQ-036 A size of 0 on one stream SHALL go straight to DRAIN; sizes of 0 on both SHALL go straight to END.
REQ-037 start outside IDLE SHALL be ignored.
REQ-038 Counters SHALL saturate at 2^SIZE_W-1 and never wrap.
REQ-039 The LFSR SHALL be a 16-bit maximal-length register, seed 16'hACE1, advancing once per matching gene.

Reset
REQ-040 On rst low, SHALL immediately (asynchronously) enter IDLE, including mid-crossover, discarding any held output.
REQ-041 On rst low, SHALL clear out_valid, gX_ready, busy, all counters and out_sel/out_innov to 0.
REQ-042 On rst low, SHALL reseed the LFSR.
REQ-043 No output SHALL glitch to 01 during reset.

Structure
REQ-044 The sel codes (SEL_G1=2'b10, SEL_G2=2'b11, SEL_END=2'b01), the FSM state encoding and the LFSR seed SHALL live in the shared package neat_xover_pkg.
REQ-045 The LFSR SHALL be a sub-module named neat_lfsr16, with an enable port and the seed as a parameter.

Verification
REQ-046 Bench SHALL cover: g1={1,2,4}, g2={1,3,4}, fit 9/5, mode 0 -> out 10(1),10(2),10(4),01; n_match=2, n_disjoint=2, n_excess=0.
REQ-047 Bench SHALL cover: g1={1,2}, g2={1,2,5,6}, fit 3/7 -> 11(1),11(2),11(5),11(6),01; n_excess=2.
REQ-048 Bench SHALL cover: equal fitness 4/4, g1={2}, g2={1,3} -> 11(1),10(2),11(3),01.
REQ-049 Bench SHALL cover: sizes 0/0, start -> busy for one END word, 01 only; out_ready low for 5 cycles -> word held stable.
REQ-050 Bench SHALL cover: random out_ready and gX_valid throttling, mode 1, 200 genomes -> no lost or duplicated gene versus a reference model.
REQ-051 Bench SHALL cover: rst low mid-MERGE -> out_valid=0 and busy=0 the same cycle; the next start runs correctly.
